// File: rtl/core_wb_arb_pkg.sv
// Shared encodings for the core Wishbone arbiter: FSM states, grant bit
// indices and the default watchdog limit.
package core_wb_arb_pkg;

  typedef enum logic [1:0] {
    WBARB_IDLE  = 2'd0,
    WBARB_G_IFU = 2'd1,
    WBARB_G_MAU = 2'd2
  } wbarb_state_t;

  localparam int WBARB_IFU = 0;
  localparam int WBARB_MAU = 1;
  localparam int WBARB_TMO = 255;

endpackage

// File: rtl/core_wb_arb_if.sv
// One Wishbone link. The master modport drives the request side; the slave
// modport returns read data and terminations.
interface core_wb_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/core_wb_tmr.sv
// 8-bit bus watchdog. tmo fires combinationally on the cycle the count of
// unanswered strobe cycles reaches TMO, and the counter restarts from zero.
module core_wb_tmr #(
  parameter int TMO = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tmo
);
  localparam logic [7:0] LIMIT = 8'(TMO - 1);

  logic [7:0] count_reg;
  logic [7:0] count_next;

  assign tmo = run && (count_reg == LIMIT);

  always_comb begin
    count_next = count_reg;
    if (clr || tmo) begin
      count_next = 8'd0;
    end else if (run) begin
      count_next = count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_next;
    end
  end
endmodule

// File: rtl/core_wb_arb.sv
// Two-master Wishbone arbiter (m0 = IFU, m1 = MAU) with per-cycle grants,
// alternating priority on contention and a watchdog that turns a hung slave into err.
module core_wb_arb
  import core_wb_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = WBARB_TMO
) (
  input  logic         clk,
  input  logic         rst,
  core_wb_arb_if.slave  m0,
  core_wb_arb_if.slave  m1,
  core_wb_arb_if.master bus,
  output logic [1:0]   gnt
);
  wbarb_state_t state_reg;
  wbarb_state_t state_next;
  logic         last_reg;   // 0 = IFU released last, 1 = MAU
  logic         last_next;

  logic sel_ifu;
  logic sel_mau;
  logic stb_mux;
  logic term_any;
  logic run;
  logic clr;
  logic tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WBARB_IDLE;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      WBARB_IDLE: begin
        if (m0.cyc && m1.cyc) begin
          state_next = last_reg ? WBARB_G_IFU : WBARB_G_MAU;
        end else if (m0.cyc) begin
          state_next = WBARB_G_IFU;
        end else if (m1.cyc) begin
          state_next = WBARB_G_MAU;
        end
      end
      WBARB_G_IFU: begin
        if (!m0.cyc) begin
          state_next = WBARB_IDLE;
          last_next  = 1'b0;
        end
      end
      WBARB_G_MAU: begin
        if (!m1.cyc) begin
          state_next = WBARB_IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = WBARB_IDLE;
    endcase
  end

  assign sel_ifu        = (state_reg == WBARB_G_IFU);
  assign sel_mau        = (state_reg == WBARB_G_MAU);
  assign gnt[WBARB_IFU] = sel_ifu;
  assign gnt[WBARB_MAU] = sel_mau;

  // Request path is a pure mux so a granted master pays no latency per beat.
  always_comb begin
    bus.cyc   = 1'b0;
    stb_mux   = 1'b0;
    bus.we    = 1'b0;
    bus.sel   = '0;
    bus.adr   = '0;
    bus.dat_w = '0;
    if (sel_ifu) begin
      bus.cyc   = m0.cyc;
      stb_mux   = m0.stb;
      bus.we    = m0.we;
      bus.sel   = m0.sel;
      bus.adr   = m0.adr;
      bus.dat_w = m0.dat_w;
    end else if (sel_mau) begin
      bus.cyc   = m1.cyc;
      stb_mux   = m1.stb;
      bus.we    = m1.we;
      bus.sel   = m1.sel;
      bus.adr   = m1.adr;
      bus.dat_w = m1.dat_w;
    end
  end

  // A real termination in the timeout cycle suppresses run, so it wins.
  assign term_any = bus.ack || bus.err || bus.rty;
  assign run      = stb_mux && !term_any;
  assign clr      = term_any || ((state_reg != WBARB_IDLE) && (state_next == WBARB_IDLE));
  assign bus.stb  = stb_mux && !tmo;

  core_wb_tmr #(.TMO(TMO)) u_tmr (
    .clk (clk),
    .rst (rst),
    .run (run),
    .clr (clr),
    .tmo (tmo)
  );

  assign m0.dat_r = bus.dat_r;
  assign m1.dat_r = bus.dat_r;
  assign m0.ack   = sel_ifu && bus.ack;
  assign m0.err   = sel_ifu && (bus.err || tmo);
  assign m0.rty   = sel_ifu && bus.rty;
  assign m1.ack   = sel_mau && bus.ack;
  assign m1.err   = sel_mau && (bus.err || tmo);
  assign m1.rty   = sel_mau && bus.rty;
endmodule

// File: tb/tb_core_wb_arb.sv
// Directed bench for core_wb_arb with a 4-cycle watchdog.
module tb_core_wb_arb;
  import core_wb_arb_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] gnt;
  int         n_cmp;
  int         n_bad;

  core_wb_arb_if #(.AW(32), .DW(32)) m0_if ();
  core_wb_arb_if #(.AW(32), .DW(32)) m1_if ();
  core_wb_arb_if #(.AW(32), .DW(32)) bus_if ();

  core_wb_arb #(.AW(32), .DW(32), .TMO(4)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if.slave),
    .m1  (m1_if.slave),
    .bus (bus_if.master),
    .gnt (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "bench time bound expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic m0_req(input logic on, input logic [31:0] a);
    m0_if.cyc = on;
    m0_if.stb = on;
    m0_if.adr = a;
  endtask

  task automatic m1_req(input logic on, input logic [31:0] a);
    m1_if.cyc = on;
    m1_if.stb = on;
    m1_if.adr = a;
  endtask

  initial begin
    int m0_left;
    int m1_left;
    logic [1:0] exp_g;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.sel = 4'hF; m0_if.adr = 0; m0_if.dat_w = 32'h1111_0000;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.sel = 4'hF; m1_if.adr = 0; m1_if.dat_w = 32'h2222_0000;
    bus_if.ack = 0; bus_if.err = 0; bus_if.rty = 0; bus_if.dat_r = 32'h0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_cyc", 32'(bus_if.cyc), 32'd0);
    chk("rst_stb", 32'(bus_if.stb), 32'd0);
    chk("rst_terms", {26'd0, m0_if.ack, m0_if.err, m0_if.rty, m1_if.ack, m1_if.err, m1_if.rty}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // MAU single read at 0x100, slave acks on the third cycle
    m1_req(1, 32'h100);
    #1;
    chk("t1_pre_cyc", 32'(bus_if.cyc), 32'd0);
    chk("t1_pre_gnt", 32'(gnt), 32'd0);
    step();
    chk("t1_gnt", 32'(gnt), 32'd2);
    chk("t1_adr", bus_if.adr, 32'h100);
    chk("t1_cyc", 32'(bus_if.cyc), 32'd1);
    step();
    step();
    bus_if.ack = 1; bus_if.dat_r = 32'hDEADBEEF;
    #1;
    chk("t1_m1_ack", 32'(m1_if.ack), 32'd1);
    chk("t1_m1_dat", m1_if.dat_r, 32'hDEADBEEF);
    chk("t1_m0_ack", 32'(m0_if.ack), 32'd0);
    chk("t1_m1_err", 32'(m1_if.err), 32'd0);
    step();
    bus_if.ack = 0;
    m1_req(0, 32'h0);
    #1;
    chk("t1_drop_cyc", 32'(bus_if.cyc), 32'd0);
    step();
    chk("t1_idle_gnt", 32'(gnt), 32'd0);

    // Contention from reset: three transfers each, strict alternation
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m0_left = 3;
    m1_left = 3;
    m0_req(1, 32'h200);
    m1_req(1, 32'h300);
    for (int i = 0; i < 6; i++) begin
      step();
      exp_g = (i % 2 == 0) ? 2'd2 : 2'd1;
      chk($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(exp_g));
      chk($sformatf("t2_cyc%0d", i), 32'(bus_if.cyc), 32'd1);
      chk($sformatf("t2_adr%0d", i), bus_if.adr, (exp_g == 2'd2) ? 32'h300 : 32'h200);
      bus_if.ack = 1;
      #1;
      chk($sformatf("t2_ack%0d", i), {30'd0, m1_if.ack, m0_if.ack}, 32'(exp_g));
      step();
      bus_if.ack = 0;
      if (exp_g == 2'd2) begin
        m1_req(0, 32'h300);
        m1_left--;
      end else begin
        m0_req(0, 32'h200);
        m0_left--;
      end
      #1;
      chk($sformatf("t2_drop%0d", i), 32'(bus_if.cyc), 32'd0);
      step();
      if (exp_g == 2'd2 && m1_left > 0) m1_req(1, 32'h300);
      if (exp_g == 2'd1 && m0_left > 0) m0_req(1, 32'h200);
      #1;
      chk($sformatf("t2_idle_gnt%0d", i), 32'(gnt), 32'd0);
      chk($sformatf("t2_idle_cyc%0d", i), 32'(bus_if.cyc), 32'd0);
    end

    // IFU burst of 4 while MAU waits
    m0_req(1, 32'h400);
    step();
    m1_req(1, 32'h500);
    for (int b = 0; b < 4; b++) begin
      bus_if.ack = 1;
      #1;
      chk($sformatf("t3_gnt%0d", b), 32'(gnt), 32'd1);
      chk($sformatf("t3_ack%0d", b), {30'd0, m1_if.ack, m0_if.ack}, 32'd1);
      step();
    end
    bus_if.ack = 0;
    m0_req(0, 32'h0);
    #1;
    chk("t3_hold_gnt", 32'(gnt), 32'd1);
    chk("t3_drop_cyc", 32'(bus_if.cyc), 32'd0);
    step();
    chk("t3_idle_gnt", 32'(gnt), 32'd0);
    step();
    chk("t3_mau_gnt", 32'(gnt), 32'd2);
    chk("t3_mau_adr", bus_if.adr, 32'h500);
    m1_req(0, 32'h0);
    step();

    // Watchdog: no response, err every 4th strobe cycle
    m1_req(1, 32'h600);
    step();
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("t4_err%0d", k), 32'(m1_if.err), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t4_stb%0d", k), 32'(bus_if.stb), (k % 4 == 0) ? 32'd0 : 32'd1);
      step();
    end
    m1_req(0, 32'h0);
    step();

    // Ack on the 4th cycle beats the watchdog and restarts it
    m1_req(1, 32'h700);
    step();
    step();
    step();
    step();
    bus_if.ack = 1;
    #1;
    chk("t5_ack", 32'(m1_if.ack), 32'd1);
    chk("t5_no_err", 32'(m1_if.err), 32'd0);
    chk("t5_stb", 32'(bus_if.stb), 32'd1);
    step();
    bus_if.ack = 0;
    for (int k = 5; k <= 8; k++) begin
      #1;
      chk($sformatf("t5_err%0d", k), 32'(m1_if.err), (k == 8) ? 32'd1 : 32'd0);
      step();
    end
    m1_req(0, 32'h0);
    step();

    // Reset mid-grant
    m1_req(1, 32'h800);
    step();
    chk("t6_stb_pre", 32'(bus_if.stb), 32'd1);
    rst = 1'b1;
    bus_if.ack = 1;
    #1;
    chk("t6_cyc", 32'(bus_if.cyc), 32'd0);
    chk("t6_stb", 32'(bus_if.stb), 32'd0);
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_ack_lost", 32'(m1_if.ack), 32'd0);
    step();
    bus_if.ack = 0;
    m0_req(1, 32'h900);
    rst = 1'b0;
    step();
    chk("t6_first_gnt", 32'(gnt), 32'd2);
    m0_req(0, 32'h0);
    m1_req(0, 32'h0);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_wb_arb.md
# core_wb_arb

Two-master Wishbone arbiter that shares the core's single external Wishbone master port between the instruction fetch path (master 0, IFU) and the memory access unit (master 1, MAU). It grants the bus per complete `cyc` cycle using alternating priority when both masters request. It routes termination signals only to the granted master. A bus watchdog converts a hung slave into an error termination. It sits between the core-internal masters and the core's top-level Wishbone pins.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TMO`, 255, watchdog limit in cycles; 8-bit counter, legal range 1..255

Ports:
- `clk`  in  1  core clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `m0_cyc_i` / `m1_cyc_i`  in  1  master cycle request
- `m0_stb_i` / `m1_stb_i`  in  1  master strobe
- `m0_we_i` / `m1_we_i`  in  1  master write enable
- `m0_sel_i` / `m1_sel_i`  in  DW/8  master byte selects
- `m0_adr_i` / `m1_adr_i`  in  AW  master address
- `m0_dat_i` / `m1_dat_i`  in  DW  master write data
- `m0_dat_o` / `m1_dat_o`  out  DW  read data; `dat_i` is fanned out to both masters
- `m0_ack_o`, `m0_err_o`, `m0_rty_o` / `m1_*`  out  1  per-master terminations
- `cyc_o`, `stb_o`, `we_o`  out  1  bus-side controls
- `sel_o`  out  DW/8  bus-side byte selects
- `adr_o`  out  AW  bus-side address
- `dat_o`  out  DW  bus-side write data
- `dat_i`  in  DW  bus-side read data
- `ack_i`, `err_i`, `rty_i`  in  1  bus-side terminations
- `gnt_o`  out  2  one-hot grant: bit0 = IFU, bit1 = MAU

## Operation
- States: `IDLE`, `G_IFU`, `G_MAU`. Encoded state and `last` pointer are registered.
- `IDLE`:
  - Only one `mX_cyc_i` is high: go to that master's grant state.
  - Both are high: grant the master not equal to `last`.
  - Neither is high: stay in `IDLE`.
- `G_x`:
  - Stay while `mx_cyc_i` = 1.
  - When `mx_cyc_i` = 0, go to `IDLE` and set `last` = x.
- Bus outputs are a combinational mux of the granted master's signals.
  - `cyc_o` = granted `cyc_i`, so it drops the same cycle the master drops.
  - In `IDLE`, all bus outputs are 0.
- Terminations:
  - `ack_i`, `err_i` and `rty_i` are forwarded only to the granted master.
  - The non-granted master sees 0.
  - In `IDLE`, terminations are discarded.
- Watchdog:
  - The counter increments each cycle `stb_o` = 1 and no `ack_i`, `err_i` or `rty_i` is present.
  - It clears on any termination, and on entry to `IDLE`.
  - When the count reaches `TMO`, the granted `mx_err_o` is pulsed for 1 cycle and `stb_o` is forced to 0 that cycle.
  - The counter then clears; the master decides whether to drop `cyc`.
- Simultaneous events:
  - A slave termination in the same cycle the count reaches `TMO`: the termination wins and no error is injected.
  - A master drops `cyc_i` while a strobe is outstanding: the cycle is abandoned, and a late `ack_i` arriving in `IDLE` is ignored.

## Timing
- Reset values, asserted asynchronously:
  - state = `IDLE`, `last` = IFU, so the MAU wins the first contention.
  - Counter = 0, `gnt_o` = 00.
  - All bus outputs and all `mX_*_o` terminations = 0.
- Arbitration latency:
  - `cyc_i` rising in cycle n gives grant in n+1; `cyc_o`/`stb_o` appear on the bus in n+1.
  - A master that is already granted sees no added latency per beat, since the path is combinational.
- Release costs exactly one `IDLE` cycle with `cyc_o` = 0 between consecutive grants, including back-to-back grants to the same master.
- Termination forwarding is combinational, with zero added cycles.
- Watchdog: with no slave response, `err` reaches the master on the `TMO`th cycle of `stb_o`.
- Reset mid-cycle: `cyc_o` drops immediately and pending terminations are lost.

## Structure
- Shared defines in `i2d_core_defines.v`:
  - State encodings `WBARB_IDLE`, `WBARB_G_IFU`, `WBARB_G_MAU`.
  - Grant bit indices `WBARB_IFU` = 0, `WBARB_MAU` = 1.
  - Default timeout `WBARB_TMO`.
- One sub-module, `core_wb_tmr`: the 8-bit watchdog counter with inputs `run`, `clr`, and `tmo` output. The FSM and mux stay in `core_wb_arb`.

## Test plan
- Reset, then MAU single read at adr 0x100, slave acks after 2 cycles:
  - Before the grant: `cyc_o` = 0.
  - Cycle 1: `gnt_o` = 10 and `adr_o` = 0x100.
  - After the ack: `m1_ack_o` pulses with data 0xDEADBEEF, and `m0_ack_o` stays 0.
- Both masters raise `cyc` together from reset, each performing 3 single transfers back-to-back:
  - Grant order is MAU, IFU, MAU, IFU, MAU, IFU.
  - Each grant is separated by exactly one `cyc_o` = 0 cycle.
- IFU burst of 4 acks while the MAU is requesting: `gnt_o` stays 01 for all 4 beats, and the MAU is granted only after IFU `cyc` drops.
- `TMO` = 4, slave never responds: on the 4th `stb_o` cycle `m1_err_o` = 1 and `stb_o` = 0; it repeats every 4 cycles if `cyc` is held.
- `TMO` = 4, `ack_i` arrives on cycle 4: only `ack` is forwarded, no `err`, and the counter clears.
- Assert `rst` mid-grant with `stb_o` = 1: outputs go to 0 within the same cycle, and after release the first contention goes to the MAU.
